// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants and FSM encoding for the UART transmit arbiter
package uart_pkg;

  // Default byte width of the shared transmitter and default requester count.
  localparam int UART_WDATA = 8;
  localparam int UART_NREQ  = 4;

  // Arbiter control states: waiting for a request, offering a beat, load strobe cycle.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } arb_state_e;

  // Index width that stays legal for a single requester.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rtl/uart_tx_arbiter_rr_pick.sv - combinational round-robin winner search
module rr_pick import uart_pkg::*; #(
  parameter int N  = UART_NREQ,
  parameter int IW = idx_width(UART_NREQ)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_idx,
  output logic [N-1:0]  win_oh,
  output logic [IW-1:0] win_idx,
  output logic          any
);

  // Scan from the slot after the previous owner, wrapping, and take the first request.
  always_comb begin
    int          j;
    logic [IW-1:0] jj;
    win_oh  = '0;
    win_idx = '0;
    any     = 1'b0;
    j       = 0;
    jj      = '0;
    for (int k = 1; k <= N; k++) begin
      j  = (int'(last_idx) + k) % N;
      jj = IW'(j);
      if (!any && req[jj]) begin
        any         = 1'b1;
        win_oh[jj]  = 1'b1;
        win_idx     = jj;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - packet-granular round-robin arbiter feeding one UART transmitter
module uart_tx_arbiter import uart_pkg::*; #(
  parameter int Nreq  = UART_NREQ,
  parameter int Wdata = UART_WDATA,
  parameter int Tidle = 1024
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [Nreq-1:0]       REQ_VALID,
  input  logic [Nreq*Wdata-1:0] REQ_DATA,
  input  logic [Nreq-1:0]       REQ_LAST,
  output logic [Nreq-1:0]       REQ_READY,
  output logic [Wdata-1:0]      TX_DIN,
  output logic                  TX_OE,
  input  logic                  TX_RDY,
  output logic [Nreq-1:0]       GNT,
  output logic                  BUSY
);

  localparam int IW = idx_width(Nreq);
  localparam int CW = (Tidle > 1) ? $clog2(Tidle) : 1;
  localparam logic [CW-1:0] CNT_MAX   = CW'(Tidle - 1);
  localparam logic [IW-1:0] LASTG_RST = IW'(Nreq - 1);

  arb_state_e        state_q, state_d;
  logic [Nreq-1:0]   gnt_q, gnt_d;
  logic [IW-1:0]     gidx_q, gidx_d;
  logic [IW-1:0]     lastg_q, lastg_d;
  logic [Wdata-1:0]  tx_din_q, tx_din_d;
  logic              tx_oe_q, tx_oe_d;
  logic              last_q, last_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  logic [Nreq-1:0]   pick_oh;
  logic [IW-1:0]     pick_idx;
  logic              pick_any;
  logic [Wdata-1:0]  sel_data;
  logic              sel_valid;
  logic              sel_last;
  logic              xfer;

  rr_pick #(
    .N  (Nreq),
    .IW (IW)
  ) u_rr_pick (
    .req      (REQ_VALID),
    .last_idx (lastg_q),
    .win_oh   (pick_oh),
    .win_idx  (pick_idx),
    .any      (pick_any)
  );

  // Route the current owner's byte, valid and last flag; all-zero when nobody owns the line.
  always_comb begin
    sel_data  = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    for (int i = 0; i < Nreq; i++) begin
      if (gnt_q[i]) begin
        sel_data  = sel_data | REQ_DATA[i*Wdata +: Wdata];
        sel_valid = sel_valid | REQ_VALID[i];
        sel_last  = sel_last | REQ_LAST[i];
      end
    end
  end

  // Only the owner is offered a slot, and only while the transmitter can take a byte.
  always_comb begin
    REQ_READY = '0;
    if (state_q == ST_ISSUE && TX_RDY) begin
      REQ_READY = gnt_q;
    end
  end

  assign xfer = (state_q == ST_ISSUE) && sel_valid && TX_RDY;

  // Next-state logic: grant in IDLE, move one byte per frame, hand back at packet end or starvation.
  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    gidx_d   = gidx_q;
    lastg_d  = lastg_q;
    tx_din_d = tx_din_q;
    tx_oe_d  = 1'b0;
    last_d   = last_q;
    cnt_d    = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          gnt_d   = pick_oh;
          gidx_d  = pick_idx;
          cnt_d   = '0;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (xfer) begin
          tx_din_d = sel_data;
          tx_oe_d  = 1'b1;
          last_d   = sel_last;
          cnt_d    = '0;
          state_d  = ST_WAIT;
        end else if (TX_RDY) begin
          // Owner went quiet while the line was free: give up after Tidle such cycles.
          if (cnt_q == CNT_MAX) begin
            lastg_d = gidx_q;
            gnt_d   = '0;
            cnt_d   = '0;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      ST_WAIT: begin
        if (last_q) begin
          lastg_d = gidx_q;
          gnt_d   = '0;
          last_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_ISSUE;
        end
      end
      default: begin
        gnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset makes requester 0 the first winner.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      gnt_q    <= '0;
      gidx_q   <= '0;
      lastg_q  <= LASTG_RST;
      tx_din_q <= '0;
      tx_oe_q  <= 1'b0;
      last_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      gidx_q   <= gidx_d;
      lastg_q  <= lastg_d;
      tx_din_q <= tx_din_d;
      tx_oe_q  <= tx_oe_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
    end
  end

  assign TX_DIN = tx_din_q;
  assign TX_OE  = tx_oe_q;
  assign GNT    = gnt_q;
  assign BUSY   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed bench for uart_tx_arbiter with a 10-cycle transmitter model
module tb_uart_tx_arbiter;

  localparam int NR    = 4;
  localparam int WD    = 8;
  localparam int TIDLE = 16;
  localparam int FRAME = 10;

  logic              CLK = 1'b0;
  logic              RST = 1'b1;
  logic [NR-1:0]     REQ_VALID;
  logic [NR*WD-1:0]  REQ_DATA;
  logic [NR-1:0]     REQ_LAST;
  logic [NR-1:0]     REQ_READY;
  logic [WD-1:0]     TX_DIN;
  logic              TX_OE;
  logic              TX_RDY;
  logic [NR-1:0]     GNT;
  logic              BUSY;

  int applied     = 0;
  int miscompares = 0;

  uart_tx_arbiter #(.Nreq(NR), .Wdata(WD), .Tidle(TIDLE)) dut (
    .CLK(CLK), .RST(RST), .REQ_VALID(REQ_VALID), .REQ_DATA(REQ_DATA),
    .REQ_LAST(REQ_LAST), .REQ_READY(REQ_READY), .TX_DIN(TX_DIN), .TX_OE(TX_OE),
    .TX_RDY(TX_RDY), .GNT(GNT), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  // transmitter model: busy FRAME cycles after each load strobe
  int   tx_cnt = 0;
  logic rdy_en = 1'b1;
  always @(posedge CLK) begin
    if (TX_OE) tx_cnt <= FRAME;
    else if (tx_cnt != 0) tx_cnt <= tx_cnt - 1;
  end
  assign TX_RDY = (tx_cnt == 0) && !TX_OE && rdy_en;

  // requester model: per-requester byte list {last,data}, offered while rd < wr and rd < lim
  logic [8:0] mem [NR][8];
  int   wr  [NR];
  int   rd  [NR];
  int   lim [NR];
  logic clr = 1'b1;

  always_comb begin
    REQ_VALID = '0;
    REQ_DATA  = '0;
    REQ_LAST  = '0;
    for (int i = 0; i < NR; i++) begin
      REQ_VALID[i]        = (rd[i] < wr[i]) && (rd[i] < lim[i]);
      REQ_DATA[i*WD +: WD] = mem[i][rd[i] % 8][7:0];
      REQ_LAST[i]         = mem[i][rd[i] % 8][8];
    end
  end

  always @(posedge CLK) begin
    logic [NR-1:0] acc;
    acc = REQ_VALID & REQ_READY;
    #1;
    for (int i = 0; i < NR; i++) begin
      if (clr) rd[i] = 0;
      else if (acc[i]) rd[i] = rd[i] + 1;
    end
  end

  // load-strobe log and always-on protocol checks
  int         cyc = 0;
  int         log_n = 0;
  logic [7:0] log_data [64];
  int         log_own  [64];
  int         log_cyc  [64];
  logic       oe_prev = 1'b0;

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (TX_OE && log_n < 64) begin
      log_data[log_n] = TX_DIN;
      log_own[log_n]  = -1;
      for (int i = 0; i < NR; i++) if (GNT[i]) log_own[log_n] = i;
      log_cyc[log_n] = cyc;
      log_n = log_n + 1;
    end
    assert ($onehot0(GNT)) else begin
      miscompares++; $error("FAIL gnt_onehot: observed %b expected one-hot or zero", GNT);
    end
    assert ($onehot0(REQ_READY)) else begin
      miscompares++; $error("FAIL ready_onehot: observed %b expected at most one bit", REQ_READY);
    end
    assert (!(TX_OE && oe_prev)) else begin
      miscompares++; $error("FAIL oe_consecutive: observed 1 expected 0");
    end
    assert (!(TX_OE && GNT == '0)) else begin
      miscompares++; $error("FAIL oe_no_owner: observed GNT %b expected nonzero", GNT);
    end
    oe_prev = TX_OE;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    applied++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic reset_all();
    clr = 1'b1;
    RST = 1'b1;
    for (int i = 0; i < NR; i++) begin
      wr[i]  = 0;
      lim[i] = 8;
    end
    repeat (12) tick();
    RST = 1'b0;
    clr = 1'b0;
  endtask

  task automatic push(input int r, input logic last, input logic [7:0] d);
    mem[r][wr[r]] = {last, d};
    wr[r] = wr[r] + 1;
  endtask

  initial begin
    int base;
    int g;
    int stall;
    for (int i = 0; i < NR; i++) begin
      wr[i] = 0; rd[i] = 0; lim[i] = 8;
      for (int k = 0; k < 8; k++) mem[i][k] = '0;
    end

    // reset values, then a single one-byte packet from requester 0
    reset_all();
    check("rst_gnt", 32'(GNT), 0);
    check("rst_oe", 32'(TX_OE), 0);
    check("rst_din", 32'(TX_DIN), 0);
    check("rst_busy", 32'(BUSY), 0);
    check("rst_ready", 32'(REQ_READY), 0);
    base = log_n;
    push(0, 1'b1, 8'h55);
    tick();
    check("t1_gnt", 32'(GNT), 32'b0001);
    check("t1_busy", 32'(BUSY), 1);
    check("t1_ready", 32'(REQ_READY), 32'b0001);
    tick();
    check("t1_oe", 32'(TX_OE), 1);
    check("t1_din", 32'(TX_DIN), 32'h55);
    check("t1_gnt_wait", 32'(GNT), 32'b0001);
    tick();
    check("t1_oe_off", 32'(TX_OE), 0);
    check("t1_gnt_clr", 32'(GNT), 0);
    check("t1_busy_off", 32'(BUSY), 0);
    repeat (20) tick();
    check("t1_pulses", 32'(log_n - base), 1);

    // all four requesters with 2-byte packets, serialized 0,1,2,3
    reset_all();
    base = log_n;
    for (int i = 0; i < NR; i++) begin
      push(i, 1'b0, 8'(8'h10 * i + 1));
      push(i, 1'b1, 8'(8'h10 * i + 2));
    end
    g = 0;
    while (log_n - base < 8 && g < 400) begin tick(); g++; end
    check("t2_timeout", 32'(g < 400), 1);
    for (int k = 0; k < 8; k++) begin
      check("t2_owner", 32'(log_own[base + k]), 32'(k / 2));
      check("t2_data", 32'(log_data[base + k]), 32'(8'h10 * (k / 2) + 1 + (k % 2)));
    end
    repeat (30) tick();
    check("t2_pulses", 32'(log_n - base), 8);

    // starvation: requester 2 stalls mid-packet, released after TIDLE ready cycles
    reset_all();
    base = log_n;
    push(2, 1'b0, 8'h21);
    push(2, 1'b1, 8'h22);
    lim[2] = 1;
    push(3, 1'b1, 8'h31);
    g = 0;
    while (!TX_OE && g < 50) begin tick(); g++; end
    check("t3_first_timeout", 32'(g < 50), 1);
    check("t3_first_owner", 32'(GNT), 32'b0100);
    check("t3_first_data", 32'(TX_DIN), 32'h21);
    stall = 0;
    g = 0;
    while (GNT == 4'b0100 && g < 100) begin
      if (TX_RDY) stall++;
      tick();
      g++;
    end
    check("t3_stall_cycles", 32'(stall), 32'(TIDLE));
    check("t3_released", 32'(GNT), 0);
    tick();
    check("t3_next_gnt", 32'(GNT), 32'b1000);
    lim[2] = 8;
    g = 0;
    while (log_n - base < 3 && g < 200) begin tick(); g++; end
    check("t3_timeout", 32'(g < 200), 1);
    check("t3_b1_data", 32'(log_data[base + 1]), 32'h31);
    check("t3_b1_owner", 32'(log_own[base + 1]), 3);
    check("t3_b2_data", 32'(log_data[base + 2]), 32'h22);
    check("t3_b2_owner", 32'(log_own[base + 2]), 2);

    // 3-byte packet against a 10-cycle frame: one strobe per frame, in order
    reset_all();
    base = log_n;
    push(1, 1'b0, 8'h41);
    push(1, 1'b0, 8'h42);
    push(1, 1'b1, 8'h43);
    g = 0;
    while (log_n - base < 3 && g < 200) begin tick(); g++; end
    check("t4_timeout", 32'(g < 200), 1);
    for (int k = 0; k < 3; k++) begin
      check("t4_data", 32'(log_data[base + k]), 32'(8'h41 + k));
      check("t4_owner", 32'(log_own[base + k]), 1);
    end
    check("t4_spacing1", 32'(log_cyc[base + 1] - log_cyc[base]), 32'(FRAME + 2));
    check("t4_spacing2", 32'(log_cyc[base + 2] - log_cyc[base + 1]), 32'(FRAME + 2));
    repeat (30) tick();
    check("t4_pulses", 32'(log_n - base), 3);

    // reset during WAIT while the transmitter is mid-frame
    reset_all();
    push(1, 1'b1, 8'h66);
    g = 0;
    while (!TX_OE && g < 50) begin tick(); g++; end
    check("t5_oe_timeout", 32'(g < 50), 1);
    RST = 1'b1;
    tick();
    check("t5_rst_gnt", 32'(GNT), 0);
    check("t5_rst_oe", 32'(TX_OE), 0);
    check("t5_rst_din", 32'(TX_DIN), 0);
    check("t5_rst_busy", 32'(BUSY), 0);
    push(0, 1'b1, 8'h77);
    push(1, 1'b1, 8'h78);
    RST = 1'b0;
    tick();
    check("t5_gnt", 32'(GNT), 32'b0001);
    base = log_n;
    g = 0;
    while (!TX_RDY && g < 30) begin tick(); g++; end
    check("t5_rdy_timeout", 32'(g < 30), 1);
    check("t5_no_oe_busy", 32'(log_n - base), 0);
    tick();
    check("t5_oe", 32'(TX_OE), 1);
    check("t5_din", 32'(TX_DIN), 32'h77);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
